// File: rtl/lts_preamble_gen.sv
// rtl/lts_preamble_gen.sv - 802.11a long training preamble source; LTS_GI2_EN adds the 32-sample GI2 prefix
module lts_preamble_gen #(
    parameter int GP_COUNTER_WIDTH = 8,
    parameter int DATA_WIDTH       = 12
) (
    input  logic                        CLK,
    input  logic                        s_RST,
    input  logic                        enable,
    input  logic                        start,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_I,
    output logic [DATA_WIDTH-1:0]       out_Q,
    output logic                        output_strobe,
    output logic [GP_COUNTER_WIDTH-1:0] Sample_Index,
    output logic                        busy,
    output logic                        done
);

    typedef enum logic [1:0] {S_IDLE, S_GI, S_SYM1, S_SYM2} state_t;

`ifdef LTS_GI2_EN
    localparam state_t     FIRST_STATE = S_GI;
    localparam logic [5:0] FIRST_ADDR  = 6'd32;
`else
    localparam state_t     FIRST_STATE = S_SYM1;
    localparam logic [5:0] FIRST_ADDR  = 6'd0;
`endif

    // {I, Q} in Q1.10; second half is the conjugate mirror of the first
    function automatic logic [23:0] lts_rom(input logic [5:0] a);
        case (a)
            6'd0:  lts_rom = {12'sd160,  12'sd0};
            6'd1:  lts_rom = {-12'sd5,   -12'sd123};
            6'd2:  lts_rom = {12'sd41,   -12'sd114};
            6'd3:  lts_rom = {12'sd99,   12'sd85};
            6'd4:  lts_rom = {12'sd22,   12'sd29};
            6'd5:  lts_rom = {12'sd61,   -12'sd90};
            6'd6:  lts_rom = {-12'sd118, -12'sd56};
            6'd7:  lts_rom = {-12'sd39,  -12'sd109};
            6'd8:  lts_rom = {12'sd100,  -12'sd27};
            6'd9:  lts_rom = {12'sd54,   12'sd4};
            6'd10: lts_rom = {12'sd1,    -12'sd118};
            6'd11: lts_rom = {-12'sd140, -12'sd48};
            6'd12: lts_rom = {12'sd25,   -12'sd60};
            6'd13: lts_rom = {12'sd60,   -12'sd15};
            6'd14: lts_rom = {-12'sd23,  12'sd165};
            6'd15: lts_rom = {12'sd122,  -12'sd4};
            6'd16: lts_rom = {12'sd63,   12'sd63};
            6'd17: lts_rom = {12'sd38,   -12'sd100};
            6'd18: lts_rom = {-12'sd58,  -12'sd40};
            6'd19: lts_rom = {-12'sd134, -12'sd67};
            6'd20: lts_rom = {12'sd84,   -12'sd94};
            6'd21: lts_rom = {12'sd72,   -12'sd14};
            6'd22: lts_rom = {-12'sd61,  -12'sd83};
            6'd23: lts_rom = {-12'sd57,  12'sd23};
            6'd24: lts_rom = {-12'sd36,  12'sd155};
            6'd25: lts_rom = {-12'sd125, 12'sd17};
            6'd26: lts_rom = {-12'sd130, 12'sd22};
            6'd27: lts_rom = {12'sd77,   12'sd76};
            6'd28: lts_rom = {-12'sd3,   -12'sd55};
            6'd29: lts_rom = {-12'sd94,  -12'sd118};
            6'd30: lts_rom = {12'sd94,   -12'sd109};
            6'd31: lts_rom = {12'sd12,   -12'sd100};
            6'd32: lts_rom = {-12'sd160, 12'sd0};
            6'd33: lts_rom = {12'sd12,   12'sd100};
            6'd34: lts_rom = {12'sd94,   12'sd109};
            6'd35: lts_rom = {-12'sd94,  12'sd118};
            6'd36: lts_rom = {-12'sd3,   12'sd55};
            6'd37: lts_rom = {12'sd77,   -12'sd76};
            6'd38: lts_rom = {-12'sd130, -12'sd22};
            6'd39: lts_rom = {-12'sd125, -12'sd17};
            6'd40: lts_rom = {-12'sd36,  -12'sd155};
            6'd41: lts_rom = {-12'sd57,  -12'sd23};
            6'd42: lts_rom = {-12'sd61,  12'sd83};
            6'd43: lts_rom = {12'sd72,   12'sd14};
            6'd44: lts_rom = {12'sd84,   12'sd94};
            6'd45: lts_rom = {-12'sd134, 12'sd67};
            6'd46: lts_rom = {-12'sd58,  12'sd40};
            6'd47: lts_rom = {12'sd38,   12'sd100};
            6'd48: lts_rom = {12'sd63,   -12'sd63};
            6'd49: lts_rom = {12'sd122,  12'sd4};
            6'd50: lts_rom = {-12'sd23,  -12'sd165};
            6'd51: lts_rom = {12'sd60,   12'sd15};
            6'd52: lts_rom = {12'sd25,   12'sd60};
            6'd53: lts_rom = {-12'sd140, 12'sd48};
            6'd54: lts_rom = {12'sd1,    12'sd118};
            6'd55: lts_rom = {12'sd54,   -12'sd4};
            6'd56: lts_rom = {12'sd100,  12'sd27};
            6'd57: lts_rom = {-12'sd39,  12'sd109};
            6'd58: lts_rom = {-12'sd118, 12'sd56};
            6'd59: lts_rom = {12'sd61,   12'sd90};
            6'd60: lts_rom = {12'sd22,   -12'sd29};
            6'd61: lts_rom = {12'sd99,   -12'sd85};
            6'd62: lts_rom = {12'sd41,   12'sd114};
            default: lts_rom = {-12'sd5, 12'sd123};
        endcase
    endfunction

    state_t                      state_q, state_d;
    logic [5:0]                  addr_q, addr_d;
    logic [GP_COUNTER_WIDTH-1:0] idx_q, idx_d;
    logic [DATA_WIDTH-1:0]       i_q, i_d, q_q, q_d;
    logic                        strobe_q, strobe_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        load;
    logic [23:0]                 rom_w;
    logic signed [11:0]          rom_i, rom_q;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        idx_d    = idx_q;
        i_d      = i_q;
        q_d      = q_q;
        strobe_d = strobe_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        load     = 1'b0;
        if (state_q == S_IDLE) begin
            if (start) begin
                state_d  = FIRST_STATE;
                addr_d   = FIRST_ADDR;
                idx_d    = '0;
                strobe_d = 1'b1;
                busy_d   = 1'b1;
                load     = 1'b1;
            end
        end else if (strobe_q && out_ready) begin
            addr_d = addr_q + 6'd1;
            idx_d  = idx_q + 1'b1;
            load   = 1'b1;
            if (addr_q == 6'd63) begin
                case (state_q)
`ifdef LTS_GI2_EN
                    S_GI:   state_d = S_SYM1;
`endif
                    S_SYM1: state_d = S_SYM2;
                    default: begin
                        state_d  = S_IDLE;
                        addr_d   = '0;
                        idx_d    = '0;
                        strobe_d = 1'b0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        load     = 1'b0;
                        i_d      = '0;
                        q_d      = '0;
                    end
                endcase
            end
        end
        rom_w = lts_rom(addr_d);
        rom_i = rom_w[23:12];
        rom_q = rom_w[11:0];
        if (load) begin
            i_d = DATA_WIDTH'(rom_i);
            q_d = DATA_WIDTH'(rom_q);
        end
    end

    always_ff @(posedge CLK) begin
        if (s_RST || !enable) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            idx_q    <= '0;
            i_q      <= '0;
            q_q      <= '0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            idx_q    <= idx_d;
            i_q      <= i_d;
            q_q      <= q_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign out_I         = i_q;
    assign out_Q         = q_q;
    assign output_strobe = strobe_q;
    assign Sample_Index  = idx_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: doc/lts_preamble_gen.md
# lts_preamble_gen

Transmit-side generator for the 802.11a long training sequence (LTS). It emits the 160-sample long preamble (32-sample GI2 followed by two 64-sample LTS symbols) as a complex I/Q stream under a valid/ready handshake, with a running burst index. It sits at the TX framing stage ahead of the short-preamble/data mux. It is the source of the pattern that the receiver's long-sync correlator and peak search lock onto, so the sample ordering and index numbering are fixed to match that path.

## Interface
- GP_COUNTER_WIDTH, 8: width of `Sample_Index`; must be ≥ 8.
- DATA_WIDTH, 12: signed I/Q width, two's complement, Q1.10 (1.0 = 1024).
- CLK  in  1  clock.
- s_RST  in  1  reset; synchronous, active-high.
- enable  in  1  block enable; low acts as a synchronous clear of all state and outputs.
- start  in  1  one-cycle request to emit one preamble burst.
- out_ready  in  1  downstream can accept a sample this cycle.
- out_I  out  DATA_WIDTH  in-phase sample.
- out_Q  out  DATA_WIDTH  quadrature sample.
- output_strobe  out  1  `out_I`, `out_Q` and `Sample_Index` are valid.
- Sample_Index  out  GP_COUNTER_WIDTH  position in burst: 0..159, or 0..127 without GI.
- busy  out  1  a burst is in progress.
- done  out  1  one-cycle pulse after the last sample is accepted.

## Operation
- Internal constant ROM of 64 complex LTS time-domain samples, t[0..63], quantized to Q1.10 with round-to-nearest.
  - t[0] = (160, 0).
  - t[32] = (−160, 0).
- FSM states: IDLE, GI, SYM1, SYM2.
  - IDLE → GI on `start` when LTS_GI2_EN is defined; IDLE → SYM1 on `start` when it is not.
  - GI emits t[32..63], then → SYM1.
  - SYM1 emits t[0..63], then → SYM2.
  - SYM2 emits t[0..63], then → IDLE with `done` = 1 for one cycle.
- Handshake: a sample is consumed in a cycle where `output_strobe` && `out_ready`.
  - On consume: advance the ROM address and `Sample_Index` and load the next sample.
  - Otherwise hold `out_I`, `out_Q` and `Sample_Index` stable.
  - `output_strobe` stays high for the whole burst, with no bubbles while `out_ready` = 1.
- `start` is sampled only in IDLE. It is ignored while `busy`.
  - The `done` cycle is IDLE, so `start` asserted in that cycle is accepted and a new burst begins back-to-back.
- `busy` = 1 in GI/SYM1/SYM2.
- Reset and `enable` = 0 (both take priority over all else):
  - State → IDLE.
  - `out_I` = `out_Q` = 0, `Sample_Index` = 0, `output_strobe` = 0, `busy` = 0, `done` = 0.
  - A burst interrupted mid-stream is discarded and is not resumed.

## Timing
- All outputs are registered.
- Latency: `start` sampled at edge N → first sample and `output_strobe` valid after edge N (cycle N+1).
- With `out_ready` held high, the burst occupies exactly 160 consecutive strobe cycles (128 without GI).
- `done` rises on the edge that consumes the last sample. In that same cycle `output_strobe`, `busy` and `Sample_Index` are back at 0.
- ROM address wrap: 63 → 0 at the GI→SYM1 and SYM1→SYM2 boundaries. No gap cycles at either boundary.

## Configuration
- LTS_GI2_EN defined: the 32-sample GI2 prefix is emitted.
  - Burst = 160 samples.
  - First sample is t[32] at index 0; t[0] of SYM1 is at index 32.
- LTS_GI2_EN undefined: the GI state is compiled out.
  - Burst = 128 samples.
  - First sample is t[0] at index 0; SYM2 starts at index 64.

## Test plan
- Reset, then `start` pulse with `out_ready` = 1 and GI enabled → strobe cycle 1: (−160, 0), index 0. Index 32: (160, 0). Index 96: (160, 0). `done` after exactly 160 strobes.
- Same stimulus with LTS_GI2_EN undefined → first sample (160, 0) at index 0. Index 32: (−160, 0). `done` after 128 strobes.
- `out_ready` low for 5 cycles while index = 40 → outputs frozen at index 40 for all 5 cycles. Index 41 follows on the first ready cycle. Total sample count unchanged.
- `start` pulsed at index 70 and again in the `done` cycle → the first pulse is ignored. The second starts a new burst with index 0 on the next cycle.
- `s_RST` asserted at index 100, then `start` → all outputs zero during reset. The new burst restarts at index 0 with the correct first sample.
- `enable` dropped for 3 cycles mid-burst → outputs zero, state IDLE. No `done` pulse is produced for the aborted burst.
